// File: rtl/maze_probe_arbiter_if.sv
// Requester-side bus of the maze probe arbiter: packed per-requester probe
// requests, one-hot accept, and one-hot response strobe with the wall bit.
interface maze_probe_arbiter_if #(
  parameter int NUM_REQ  = 5,
  parameter int ROW_BITS = 9,
  parameter int COL_BITS = 10
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*ROW_BITS-1:0] req_row;
  logic [NUM_REQ*COL_BITS-1:0] req_col;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic                        rsp_wall;

  modport master (
    output req_valid, req_row, req_col,
    input  req_ready, rsp_valid, rsp_wall
  );

  modport slave (
    input  req_valid, req_row, req_col,
    output req_ready, rsp_valid, rsp_wall
  );
endinterface

// File: rtl/maze_probe_arbiter.sv
// Round-robin time-sharing of one synchronous maze row ROM between the sprite
// movers; one wall bit is returned per accepted (row, col) probe.
module maze_probe_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int ROW_BITS = 9,
  parameter int COL_BITS = 10,
  parameter int MAZE_W   = 640,
  parameter int MAZE_H   = 480
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_frame_start,
  maze_probe_arbiter_if.slave bus,
  output logic [ROW_BITS-1:0] o_rom_addr,
  input  logic [MAZE_W-1:0]   i_rom_data,
  output logic                o_busy,
  output logic [7:0]          o_probe_count,
  output logic                o_frame_overrun
);

  localparam int                  ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0]     LAST_ID  = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]       NUM_EXT  = (ID_W + 1)'(NUM_REQ);
  localparam logic [ROW_BITS-1:0] ROW_LIM  = ROW_BITS'(MAZE_H);
  localparam logic [COL_BITS-1:0] COL_LIM  = COL_BITS'(MAZE_W);
  localparam logic [7:0]          CNT_MAX  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
    id_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  state_t               r_state;
  state_t               w_next_state;
  logic [ID_W-1:0]      r_rr_ptr;
  logic [ID_W-1:0]      r_id;
  logic [ROW_BITS-1:0]  r_row;
  logic [COL_BITS-1:0]  r_col;
  logic [ROW_BITS-1:0]  r_rom_addr;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic                 r_rsp_wall;
  logic                 r_busy;
  logic [7:0]           r_probe_count;
  logic                 r_frame_overrun;

  logic                 w_win_found;
  logic [ID_W-1:0]      w_win_id;
  logic [ID_W:0]        w_sum;
  logic [ID_W-1:0]      w_cand;
  logic                 w_hs;
  logic [NUM_REQ-1:0]   w_ready;
  logic [ROW_BITS-1:0]  w_win_row;
  logic [COL_BITS-1:0]  w_win_col;
  logic [ID_W-1:0]      w_ptr_next;
  logic                 w_wall;

  // Round-robin search: first asserted requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum       = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      w_cand      = (w_sum >= NUM_EXT) ? ID_W'(w_sum - NUM_EXT) : ID_W'(w_sum);
      w_win_id    = (!w_win_found && bus.req_valid[w_cand]) ? w_cand : w_win_id;
      w_win_found = w_win_found | bus.req_valid[w_cand];
    end
  end

  assign w_win_row  = bus.req_row[int'(w_win_id) * ROW_BITS +: ROW_BITS];
  assign w_win_col  = bus.req_col[int'(w_win_id) * COL_BITS +: COL_BITS];
  assign w_ptr_next = (w_win_id == LAST_ID) ? '0 : w_win_id + ID_W'(1);
  // Out-of-maze probes read as solid wall without trusting the ROM bit.
  assign w_wall     = ((r_col >= COL_LIM) || (r_row >= ROW_LIM)) ? 1'b1 : i_rom_data[r_col];

  // Next-state and the combinational accept, offered only while idle.
  always_comb begin
    w_next_state = r_state;
    w_ready      = '0;
    w_hs         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hs         = w_win_found;
        w_ready      = w_win_found ? id_to_onehot(w_win_id) : '0;
        w_next_state = w_win_found ? ST_ISSUE : ST_IDLE;
      end
      ST_ISSUE:  w_next_state = ST_SAMPLE;
      ST_SAMPLE: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Probe capture on handshake; the ROM address is held until the next accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_rom_addr <= '0;
    end else if (w_hs) begin
      r_rr_ptr   <= w_ptr_next;
      r_id       <= w_win_id;
      r_row      <= w_win_row;
      r_col      <= w_win_col;
      r_rom_addr <= w_win_row;
    end else begin
      r_rr_ptr   <= r_rr_ptr;
      r_id       <= r_id;
      r_row      <= r_row;
      r_col      <= r_col;
      r_rom_addr <= r_rom_addr;
    end
  end

  // Response strobe and held wall bit, plus the busy flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_wall  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rsp_valid <= (r_state == ST_SAMPLE) ? id_to_onehot(r_id) : '0;
      r_rsp_wall  <= (r_state == ST_SAMPLE) ? w_wall : r_rsp_wall;
      r_busy      <= (w_next_state != ST_IDLE);
    end
  end

  // Per-frame probe accounting and the sticky overrun flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_probe_count   <= 8'd0;
      r_frame_overrun <= 1'b0;
    end else begin
      if (i_frame_start) begin
        r_probe_count <= w_hs ? 8'd1 : 8'd0;
      end else if (w_hs && (r_probe_count != CNT_MAX)) begin
        r_probe_count <= r_probe_count + 8'd1;
      end else begin
        r_probe_count <= r_probe_count;
      end
      r_frame_overrun <= r_frame_overrun |
                         (i_frame_start & ((r_state != ST_IDLE) | (|bus.req_valid)));
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_wall    = r_rsp_wall;
  assign o_rom_addr      = r_rom_addr;
  assign o_busy          = r_busy;
  assign o_probe_count   = r_probe_count;
  assign o_frame_overrun = r_frame_overrun;

endmodule

// File: tb/tb_maze_probe_arbiter.sv
// Directed bench for maze_probe_arbiter: a cycle-level reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_maze_probe_arbiter;
  localparam int NUM_REQ  = 5;
  localparam int ROW_BITS = 9;
  localparam int COL_BITS = 10;
  localparam int MAZE_W   = 640;
  localparam int MAZE_H   = 480;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                frame_start = 1'b0;
  logic [ROW_BITS-1:0] rom_addr;
  logic [MAZE_W-1:0]   rom_data;
  logic                busy;
  logic [7:0]          probe_count;
  logic                frame_overrun;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  maze_probe_arbiter_if #(.NUM_REQ(NUM_REQ), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS)) bus ();

  maze_probe_arbiter #(
    .NUM_REQ(NUM_REQ), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS),
    .MAZE_W(MAZE_W), .MAZE_H(MAZE_H)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .bus(bus),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_busy(busy),
    .o_probe_count(probe_count), .o_frame_overrun(frame_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Maze contents: a wall wherever (row + col) is a multiple of 3.
  function automatic logic maze_bit(int r, int c);
    return ((r + c) % 3) == 0;
  endfunction

  function automatic logic [MAZE_W-1:0] maze_row(int r);
    logic [MAZE_W-1:0] v;
    for (int c = 0; c < MAZE_W; c++) v[c] = maze_bit(r, c);
    return v;
  endfunction

  always @(posedge clk) rom_data <= maze_row(int'(rom_addr));

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // m_age counts cycles since the last accept; 4 means nothing in flight.
  int   m_age = 4;
  int   m_ptr = 0;
  int   m_count = 0;
  bit   m_ovr = 1'b0;
  int   m_addr = 0;
  bit   m_wall = 1'b0;
  int   m_id = 0;
  bit   m_pend_wall = 1'b0;
  int   m_pick;
  int   m_prow;
  int   m_pcol;
  logic [NUM_REQ-1:0] e_ready;
  logic [NUM_REQ-1:0] e_rsp;

  function automatic int rr_pick(logic [NUM_REQ-1:0] v, int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  always_comb begin
    m_pick  = (m_age >= 4) ? rr_pick(bus.req_valid, m_ptr) : -1;
    m_prow  = int'(bus.req_row[((m_pick < 0) ? 0 : m_pick) * ROW_BITS +: ROW_BITS]);
    m_pcol  = int'(bus.req_col[((m_pick < 0) ? 0 : m_pick) * COL_BITS +: COL_BITS]);
    e_ready = (m_pick >= 0) ? (NUM_REQ'(1) << m_pick) : '0;
    e_rsp   = (m_age == 3) ? (NUM_REQ'(1) << m_id) : '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_age <= 4; m_ptr <= 0; m_count <= 0; m_ovr <= 1'b0;
      m_addr <= 0; m_wall <= 1'b0; m_id <= 0; m_pend_wall <= 1'b0;
    end else begin
      if (frame_start && ((m_age < 4) || (bus.req_valid != '0))) m_ovr <= 1'b1;
      if (frame_start) m_count <= (m_pick >= 0) ? 1 : 0;
      else if (m_pick >= 0 && m_count < 255) m_count <= m_count + 1;
      if (m_age == 2) m_wall <= m_pend_wall;
      if (m_pick >= 0) begin
        m_age       <= 1;
        m_id        <= m_pick;
        m_ptr       <= (m_pick + 1) % NUM_REQ;
        m_addr      <= m_prow;
        m_pend_wall <= (m_pcol >= MAZE_W || m_prow >= MAZE_H) ? 1'b1 : maze_bit(m_prow, m_pcol);
      end else if (m_age < 4) begin
        m_age <= m_age + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("req_ready", 32'(bus.req_ready), 32'(e_ready));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(e_rsp));
    check("rsp_wall", 32'(bus.rsp_wall), 32'(m_wall));
    check("rom_addr", 32'(rom_addr), 32'(m_addr));
    check("busy", 32'(busy), 32'((m_age >= 1) && (m_age <= 3)));
    check("probe_count", 32'(probe_count), 32'(m_count));
    check("frame_overrun", 32'(frame_overrun), 32'(m_ovr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int id, int row, int col);
    bus.req_row[id * ROW_BITS +: ROW_BITS] = ROW_BITS'(row);
    bus.req_col[id * COL_BITS +: COL_BITS] = COL_BITS'(col);
    bus.req_valid[id] = 1'b1;
  endtask

  // Waits for the accept of requester id; returns in cycle t+1, valid dropped.
  task automatic wait_accept(int id, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      #1;
      if (bus.req_ready[id]) ok = 1'b1;
      tick();
    end
    bus.req_valid[id] = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout requester %0d: no req_ready within 20 cycles", id);
    end
  endtask

  // Full probe; returns during the response cycle t+3.
  task automatic probe(int id, int row, int col, output logic [8:0] addr_t1,
                       output logic [4:0] rsp_t3, output logic wall_t3);
    bit ok;
    set_req(id, row, col);
    wait_accept(id, ok);
    addr_t1 = rom_addr;
    tick(); tick();
    rsp_t3 = bus.rsp_valid;
    wall_t3 = bus.rsp_wall;
  endtask

  initial begin
    int         grants[$];
    int         gcyc[$];
    int         gi;
    int         strobes;
    bit         ok;
    logic [8:0] a1;
    logic [4:0] r3;
    logic       w3;

    bus.req_valid = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(probe_count), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fairness: everyone requests continuously from reset.
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 10 * i + 3, 20 * i + 1);
    for (int n = 0; n < 80 && grants.size() < 10; n++) begin
      #1;
      gi = -1;
      for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] && bus.req_valid[i]) gi = i;
      if (gi >= 0) begin grants.push_back(gi); gcyc.push_back(cyc_cnt); end
      tick();
      if (grants.size() == 10) bus.req_valid = '0;
    end
    bus.req_valid = '0;
    check("fair_grant_total", 32'(grants.size()), 32'd10);
    for (int i = 0; i < grants.size(); i++) begin
      check("fair_order", 32'(grants[i]), 32'(i % NUM_REQ));
      if (i > 0) check("fair_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd4);
    end
    tick(); tick(); tick(); tick();
    check("fair_count", 32'(probe_count), 32'd10);

    // Single probe from Pac-Man: row 65 col 49 is a wall.
    probe(0, 65, 49, a1, r3, w3);
    check("single_addr", 32'(a1), 32'd65);
    check("single_rsp", 32'(r3), 32'h01);
    check("single_wall", 32'(w3), 32'd1);
    tick();

    // Bounds: out-of-maze column or row reads as wall; an in-range open cell does not.
    probe(0, 100, 640, a1, r3, w3);
    check("bound_col_rsp", 32'(r3), 32'h01);
    check("bound_col_wall", 32'(w3), 32'd1);
    tick();
    probe(1, 480, 5, a1, r3, w3);
    check("bound_row_rsp", 32'(r3), 32'h02);
    check("bound_row_wall", 32'(w3), 32'd1);
    tick();
    probe(2, 101, 5, a1, r3, w3);
    check("open_cell_rsp", 32'(r3), 32'h04);
    check("open_cell_wall", 32'(w3), 32'd0);
    tick();

    // Frame boundary while a probe is in flight.
    set_req(3, 65, 49);
    wait_accept(3, ok);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("frame_overrun_set", 32'(frame_overrun), 32'd1);
    check("frame_count_clear", 32'(probe_count), 32'd0);
    tick();
    check("frame_inflight_rsp", 32'(bus.rsp_valid), 32'h08);
    check("frame_inflight_wall", 32'(bus.rsp_wall), 32'd1);
    tick(); tick();
    check("frame_overrun_sticky", 32'(frame_overrun), 32'd1);

    // Saturation of the probe counter.
    for (int n = 0; n < 300; n++) begin
      probe(n % NUM_REQ, n % MAZE_H, (n * 7) % MAZE_W, a1, r3, w3);
      tick();
    end
    check("sat_count", 32'(probe_count), 32'd255);
    set_req(0, 7, 8);
    frame_start = 1'b1;
    #1;
    check("sat_frame_ready", 32'(bus.req_ready), 32'h01);
    tick();
    frame_start = 1'b0;
    bus.req_valid = '0;
    check("sat_frame_count", 32'(probe_count), 32'd1);
    tick(); tick(); tick();

    // Reset asserted during SAMPLE drops the probe.
    set_req(4, 65, 49);
    wait_accept(4, ok);
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_wall", 32'(bus.rsp_wall), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(probe_count), 32'd0);
    check("rst_overrun", 32'(frame_overrun), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    strobes = 0;
    for (int n = 0; n < 6; n++) begin
      if (bus.rsp_valid != '0) strobes++;
      tick();
    end
    check("rst_dropped_probe", 32'(strobes), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
